imem_ctrl: RTL and testbench
============================

# imem_ctrl

Sequencing and arbitration controller for the writable instruction memory of the 5-stage RV32I pipeline. It shares the single memory port between the IF-stage fetch path and a word-serial program loader. During a load it holds the pipeline in stall, then pulses a pipeline restart so execution resumes at PC 0 with the new image. Sits between the IF stage, the loader (UART/debug bridge) and the instruction RAM (combinational read, synchronous write).

## Interface
- DEPTH, 128: instruction words in memory; word index is addr[8:2].
- AW, 7: word-address width, log2(DEPTH).
- clk  in  1  system clock, all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- if_req  in  1  IF stage requests a fetch this cycle.
- if_addr  in  AW  fetch word address (PC[8:2]).
- if_instr  out  32  registered fetched instruction.
- if_valid  out  1  if_instr holds the result of the previous cycle's accepted request.
- if_stall  out  1  fetch refused this cycle; IF must hold PC.
- ld_start  in  1  request to begin a program load (single-cycle pulse).
- ld_valid  in  1  ld_data carries a word.
- ld_last  in  1  qualifies ld_valid: final word of image.
- ld_data  in  32  instruction word to write.
- ld_ready  out  1  controller accepts a word this cycle.
- ld_done  out  1  one-cycle pulse, load finished.
- ld_ovf  out  1  sticky: loader supplied more than DEPTH words; cleared on next ld_start.
- ld_count  out  AW+1  words written by the last/current load.
- cpu_rst  out  1  one-cycle pipeline restart pulse (PC := 0, flush IF/ID..MEM/WB).
- mem_addr  out  AW  memory word address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory combinational read data.

## Operation
- States: RUN, LOAD, RESTART. Reset enters RUN.
- RUN: mem_addr = if_addr, mem_we = 0, if_stall = 0, ld_ready = 0. if_req → if_instr <= mem_rdata, if_valid <= 1 next cycle; no if_req → if_valid <= 0, if_instr holds.
- RUN & ld_start → LOAD; load_ptr <= 0, ld_count <= 0, ld_ovf <= 0. A fetch requested in the same cycle is still served.
- LOAD: if_stall = 1, if_valid <= 0, ld_ready = 1, mem_addr = load_ptr, mem_wdata = ld_data, mem_we = ld_valid.
  - Each ld_valid: load_ptr++, ld_count++.
  - ld_valid & ld_last → RESTART.
  - ld_valid on word DEPTH-1 without ld_last → RESTART, ld_ovf <= 1 (remaining words are never accepted).
  - ld_start in LOAD is ignored.
- RESTART (one cycle): if_stall = 1, ld_ready = 0, mem_we = 0, cpu_rst = 1, ld_done = 1; → RUN.
- ld_count saturates at DEPTH; it holds after load until the next ld_start.
- Reset mid-load: immediate return to RUN. Words already written remain in memory. No ld_done or cpu_rst is issued.

## Timing
- Reset values: if_instr 0x00000000, if_valid 0, if_stall 0, ld_ready 0, ld_done 0, ld_ovf 0, ld_count 0, cpu_rst 0, mem_we 0, mem_addr 0, mem_wdata 0.
- Fetch latency: 1 cycle (request edge N, data valid after edge N+1).
- Load word write: same cycle as ld_valid & ld_ready. Throughput 1 word/cycle.
- ld_start to ld_ready high: 1 cycle.
- Last word to cpu_rst/ld_done: 1 cycle. First fetch allowed in the cycle after RESTART.
- mem_we is never asserted outside LOAD. if_valid is never asserted in LOAD or RESTART.

## Test plan
- Reset, RUN, memory preloaded ROM[3]=0x00310233; if_req with if_addr=3 → next cycle if_instr=0x00310233, if_valid=1, if_stall=0.
- ld_start plus 4 words 0x00A00113, 0x01400193, 0x00310233, 0x0000006F (last on 4th) → mem_we on 4 cycles at addr 0..3, if_stall=1 throughout, then ld_done=cpu_rst=1 for one cycle, ld_count=4, fetch addr 1 returns 0x01400193.
- Loader inserts bubbles (ld_valid low 3 cycles mid-image) → no writes during bubbles, load_ptr holds, final ld_count correct.
- Stream 130 words with no ld_last → 128 writes, ld_ovf=1, ld_count=128, RESTART after word 127, ld_ready=0 afterwards.
- ld_start and if_req(addr 5) in the same cycle → fetch data valid next cycle, LOAD entered, if_stall=1 from that cycle.
- rstn low after 2 words of a load → all outputs return to reset values asynchronously, state RUN, ld_done/cpu_rst never pulse, addr 0..1 keep the new words.

Source files
------------

// File: rtl/imem_ctrl.sv
// imem_ctrl: sequencing and arbitration controller for the writable
// instruction memory of the RV32I pipeline. The single memory port is shared
// between IF-stage fetches (RUN) and a word-serial program loader (LOAD).
// Completing a load produces a one-cycle RESTART that pulses cpu_rst and
// ld_done, so the pipeline resumes at PC 0 with the new image.
//
// Ports:
//   clk, rstn             clock, asynchronous active-low reset
//   if_req/if_addr        fetch request and word address from IF
//   if_instr/if_valid     registered fetch result (1-cycle latency)
//   if_stall              fetch refused; IF must hold PC
//   ld_start              begin a program load (pulse)
//   ld_valid/ld_last      loader word strobe / final-word qualifier
//   ld_data               word to write
//   ld_ready              controller accepts a word this cycle
//   ld_done/cpu_rst       one-cycle end-of-load / pipeline restart pulses
//   ld_ovf                sticky: image longer than DEPTH words
//   ld_count              words written by the last/current load
//   mem_addr/we/wdata     memory port (synchronous write)
//   mem_rdata             memory combinational read data
module imem_ctrl #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 7
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [31:0]   if_instr,
    output logic          if_valid,
    output logic          if_stall,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic          ld_last,
    input  logic [31:0]   ld_data,
    output logic          ld_ready,
    output logic          ld_done,
    output logic          ld_ovf,
    output logic [AW:0]   ld_count,
    output logic          cpu_rst,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        S_RUN,
        S_LOAD,
        S_RESTART
    } state_e;

    localparam logic [AW:0]   COUNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] load_ptr_q, load_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   instr_q, instr_d;
    logic          valid_q, valid_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_RUN;
            load_ptr_q <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_ptr_q <= load_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_ptr_d = load_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        instr_d    = instr_q;
        valid_d    = 1'b0;
        if_stall   = 1'b0;
        ld_ready   = 1'b0;
        ld_done    = 1'b0;
        cpu_rst    = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;

        unique case (state_q)
            S_RUN: begin
                mem_addr = if_addr;
                // A fetch in the ld_start cycle is still served.
                if (if_req) begin
                    instr_d = mem_rdata;
                    valid_d = 1'b1;
                end
                if (ld_start) begin
                    state_d    = S_LOAD;
                    load_ptr_d = '0;
                    count_d    = '0;
                    ovf_d      = 1'b0;
                end
            end

            S_LOAD: begin
                if_stall  = 1'b1;
                ld_ready  = 1'b1;
                mem_addr  = load_ptr_q;
                mem_wdata = ld_data;
                mem_we    = ld_valid;
                if (ld_valid) begin
                    load_ptr_d = load_ptr_q + 1'b1;
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + 1'b1;
                    end
                    if (ld_last) begin
                        state_d = S_RESTART;
                    end else if (load_ptr_q == LAST_PTR) begin
                        // Memory full but image not finished: stop accepting.
                        state_d = S_RESTART;
                        ovf_d   = 1'b1;
                    end
                end
            end

            S_RESTART: begin
                if_stall = 1'b1;
                cpu_rst  = 1'b1;
                ld_done  = 1'b1;
                state_d  = S_RUN;
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    assign if_instr = instr_q;
    assign if_valid = valid_q;
    assign ld_ovf   = ovf_q;
    assign ld_count = count_q;

endmodule

// File: tb/tb_imem_ctrl.sv
module tb_imem_ctrl;

    localparam int DEPTH = 128;
    localparam int AW    = 7;

    logic          clk = 1'b0;
    logic          rstn;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_instr;
    logic          if_valid;
    logic          if_stall;
    logic          ld_start;
    logic          ld_valid;
    logic          ld_last;
    logic [31:0]   ld_data;
    logic          ld_ready;
    logic          ld_done;
    logic          ld_ovf;
    logic [AW:0]   ld_count;
    logic          cpu_rst;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Instruction RAM: combinational read, synchronous write, plus a
    // back-door port used only to preload a ROM image.
    logic [31:0]   mem [DEPTH];
    logic [31:0]   ref_mem [DEPTH];
    logic          bk_we = 1'b0;
    logic [AW-1:0] bk_addr = '0;
    logic [31:0]   bk_data = '0;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else if (bk_we) mem[bk_addr] <= bk_data;
    end
    assign mem_rdata = mem[mem_addr];

    // Count restart/done pulses across the whole run.
    int done_pulses = 0;
    int rst_pulses  = 0;
    always @(negedge clk) begin
        if (ld_done === 1'b1) done_pulses++;
        if (cpu_rst === 1'b1) rst_pulses++;
    end

    logic [31:0] exp_instr = '0;
    int          exp_pulses = 0;

    always #5 clk = ~clk;

    imem_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_instr(if_instr),
        .if_valid(if_valid), .if_stall(if_stall),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_last(ld_last),
        .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done),
        .ld_ovf(ld_ovf), .ld_count(ld_count), .cpu_rst(cpu_rst),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; if_req = 1'b0; if_addr = '0; ld_start = 1'b0;
        ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
        #3;
        n_checks++;
        if ({if_instr, if_valid, if_stall, ld_ready, ld_done, ld_ovf, ld_count,
             cpu_rst, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: instr=%h valid=%b stall=%b ready=%b done=%b ovf=%b cnt=%0d rst=%b we=%b addr=%0d wdata=%h, required all zero",
                     if_instr, if_valid, if_stall, ld_ready, ld_done, ld_ovf, ld_count,
                     cpu_rst, mem_we, mem_addr, mem_wdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic preload;
        for (int i = 0; i < DEPTH; i++) begin
            bk_we   = 1'b1;
            bk_addr = 7'(i);
            bk_data = (i == 3) ? 32'h0031_0233 : $urandom;
            ref_mem[i] = bk_data;
            tick;
        end
        bk_we = 1'b0;
    endtask

    task automatic fetch_one(input int addr, input string name);
        if_req = 1'b1; if_addr = 7'(addr);
        #1;
        n_checks++;
        if (if_stall !== 1'b0) begin
            n_fail++; $display("FAIL %s_stall: got %b required 0", name, if_stall);
        end
        tick;
        if_req = 1'b0;
        exp_instr = ref_mem[addr];
        n_checks++;
        if (if_valid !== 1'b1 || if_instr !== exp_instr) begin
            n_fail++;
            $display("FAIL %s: valid=%b instr=%h required valid=1 instr=%h", name, if_valid, if_instr, exp_instr);
        end
    endtask

    task automatic test_fetch(input int cycles);
        logic     req;
        logic [6:0] a;
        fetch_one(3, "fetch_rom3");
        for (int c = 0; c < cycles; c++) begin
            req = 1'($urandom);
            a   = 7'($urandom);
            if_req = req; if_addr = a;
            #1;
            n_checks++;
            if (if_stall !== 1'b0 || ld_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== a) begin
                n_fail++;
                $display("FAIL run_port: stall=%b ready=%b we=%b addr=%0d required 0 0 0 %0d",
                         if_stall, ld_ready, mem_we, mem_addr, a);
            end
            tick;
            if (req) exp_instr = ref_mem[a];
            n_checks++;
            if (if_valid !== req || if_instr !== exp_instr) begin
                n_fail++;
                $display("FAIL fetch_rand: valid=%b instr=%h required valid=%b instr=%h",
                         if_valid, if_instr, req, exp_instr);
            end
        end
        if_req = 1'b0;
    endtask

    // Drives one complete load. n words, optional ld_last on word n-1,
    // optional 3-cycle bubble after word 2, optional fetch in the start cycle.
    task automatic test_load(input int n, input bit use_last, input bit bubbles,
                             input int fetch_addr, input bit use_dir);
        logic [31:0] dir [4];
        int          acc = 0;
        int          cyc = 0;
        int          bub = 3;
        bit          finished = 0;
        bit          exp_ovf;
        bit          v, l;
        logic [31:0] d;
        int          bad;
        dir[0] = 32'h00A0_0113; dir[1] = 32'h0140_0193;
        dir[2] = 32'h0031_0233; dir[3] = 32'h0000_006F;

        ld_start = 1'b1;
        if (fetch_addr >= 0) begin
            if_req = 1'b1; if_addr = 7'(fetch_addr);
        end else begin
            if_req = 1'b0;
        end
        tick;
        ld_start = 1'b0;
        if (fetch_addr >= 0) begin
            exp_instr = ref_mem[fetch_addr];
            n_checks++;
            if (if_valid !== 1'b1 || if_instr !== exp_instr) begin
                n_fail++;
                $display("FAIL start_fetch: valid=%b instr=%h required 1 %h", if_valid, if_instr, exp_instr);
            end
        end
        n_checks++;
        if (ld_ready !== 1'b1 || if_stall !== 1'b1 || ld_ovf !== 1'b0 || ld_count !== '0) begin
            n_fail++;
            $display("FAIL load_entry: ready=%b stall=%b ovf=%b cnt=%0d required 1 1 0 0",
                     ld_ready, if_stall, ld_ovf, ld_count);
        end

        while (!finished && cyc < 400) begin
            v = 1'b1;
            if (bubbles && acc == 2 && bub > 0) begin
                v = 1'b0; bub--;
            end
            l = v ? (use_last && acc == n - 1) : 1'($urandom);
            d = (use_dir && acc < 4) ? dir[acc] : $urandom;
            ld_valid = v; ld_last = l; ld_data = d;
            if_req = 1'($urandom); if_addr = 7'($urandom);
            #1;
            n_checks++;
            if (ld_ready !== 1'b1 || if_stall !== 1'b1 || mem_we !== v || cpu_rst !== 1'b0 ||
                ld_count !== 8'(acc) || (v && (mem_addr !== 7'(acc) || mem_wdata !== d))) begin
                n_fail++;
                $display("FAIL load_cycle: ready=%b stall=%b we=%b rst=%b cnt=%0d addr=%0d wdata=%h required 1 1 %b 0 %0d %0d %h",
                         ld_ready, if_stall, mem_we, cpu_rst, ld_count, mem_addr, mem_wdata, v, acc, acc, d);
            end
            if (cyc > 0 || fetch_addr < 0) begin
                n_checks++;
                if (if_valid !== 1'b0) begin
                    n_fail++; $display("FAIL load_valid: got %b required 0", if_valid);
                end
            end
            tick;
            if (v) begin
                ref_mem[acc] = d;
                acc++;
                if (l || acc == DEPTH) finished = 1;
            end
            cyc++;
        end
        if (!finished) begin
            n_checks++; n_fail++;
            $display("FAIL load_timeout: accepted %0d words required completion", acc);
        end

        exp_ovf = (acc == DEPTH) && !(use_last && n == DEPTH);
        if_req = 1'b0;
        ld_valid = (n > acc) ? 1'b1 : 1'b0;
        ld_last = 1'b0; ld_data = $urandom;
        #1;
        n_checks++;
        if (cpu_rst !== 1'b1 || ld_done !== 1'b1 || if_stall !== 1'b1 || ld_ready !== 1'b0 ||
            mem_we !== 1'b0 || if_valid !== 1'b0 || ld_count !== 8'(acc) || ld_ovf !== exp_ovf) begin
            n_fail++;
            $display("FAIL restart: rst=%b done=%b stall=%b ready=%b we=%b valid=%b cnt=%0d ovf=%b required 1 1 1 0 0 0 %0d %b",
                     cpu_rst, ld_done, if_stall, ld_ready, mem_we, if_valid, ld_count, ld_ovf, acc, exp_ovf);
        end
        exp_pulses++;
        tick;
        n_checks++;
        if (cpu_rst !== 1'b0 || ld_done !== 1'b0 || if_stall !== 1'b0 || ld_ready !== 1'b0 ||
            mem_we !== 1'b0 || if_valid !== 1'b0 || ld_count !== 8'(acc) || ld_ovf !== exp_ovf) begin
            n_fail++;
            $display("FAIL after_restart: rst=%b done=%b stall=%b ready=%b we=%b valid=%b cnt=%0d ovf=%b required 0 0 0 0 0 0 %0d %b",
                     cpu_rst, ld_done, if_stall, ld_ready, mem_we, if_valid, ld_count, ld_ovf, acc, exp_ovf);
        end
        ld_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL mem_image: %0d words differ, required 0", bad);
        end
    endtask

    task automatic test_reset_midload;
        logic [31:0] d;
        ld_start = 1'b1; if_req = 1'b0;
        tick;
        ld_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d = $urandom;
            ld_valid = 1'b1; ld_last = 1'b0; ld_data = d;
            tick;
            ref_mem[i] = d;
        end
        ld_data = $urandom; if_addr = '0;
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({if_instr, if_valid, if_stall, ld_ready, ld_done, ld_ovf, ld_count,
             cpu_rst, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL midload_reset: stall=%b ready=%b done=%b cnt=%0d rst=%b we=%b addr=%0d required all zero",
                     if_stall, ld_ready, ld_done, ld_count, cpu_rst, mem_we, mem_addr);
        end
        exp_instr = '0;
        tick;
        @(negedge clk);
        rstn = 1'b1; ld_valid = 1'b0;
        tick;
        n_checks++;
        if (if_stall !== 1'b0 || ld_ready !== 1'b0 || cpu_rst !== 1'b0 || ld_done !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_run: stall=%b ready=%b rst=%b done=%b required 0 0 0 0",
                     if_stall, ld_ready, cpu_rst, ld_done);
        end
        n_checks++;
        if (mem[0] !== ref_mem[0] || mem[1] !== ref_mem[1] || mem[2] !== ref_mem[2]) begin
            n_fail++;
            $display("FAIL midload_mem: %h %h %h required %h %h %h",
                     mem[0], mem[1], mem[2], ref_mem[0], ref_mem[1], ref_mem[2]);
        end
        fetch_one(0, "fetch_after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        preload;
        test_fetch(30);
        test_load(4, 1'b1, 1'b0, -1, 1'b1);
        fetch_one(1, "fetch_loaded1");
        n_checks++;
        if (if_instr !== 32'h0140_0193) begin
            n_fail++; $display("FAIL loaded_word1: got %h required 01400193", if_instr);
        end
        test_load(7, 1'b1, 1'b1, -1, 1'b0);
        test_fetch(10);
        test_load(130, 1'b0, 1'b0, -1, 1'b0);
        test_load(3, 1'b1, 1'b0, 5, 1'b0);
        test_fetch(10);
        test_reset_midload;
        repeat (2) tick;
        n_checks++;
        if (done_pulses != exp_pulses || rst_pulses != exp_pulses) begin
            n_fail++;
            $display("FAIL pulse_count: done=%0d rst=%0d required %0d", done_pulses, rst_pulses, exp_pulses);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
